debounce_pulse: RTL

- Conditions a raw, asynchronous push-button input into a clean single-cycle enable pulse that drives the 4-bit counter's `ena` input directly.
- The counter therefore advances exactly once per physical press.
- Internally: a synchroniser, a debounce state machine with a stability counter, and a rising-edge pulse generator.
- Sits immediately upstream of the counter, in the same clock domain.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_pulse_sync.sv | 32 +++
 rtl/debounce_pulse.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared state encoding and counter sizing helper for the debounce_pulse block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val inclusive (at least 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_pulse_sync.sv
// btn_sync: SYNC_STAGES-deep flop chain bringing the raw button into the clk domain.
module btn_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic syn_reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;

  assign sync_next[0] = d;

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// Push-button conditioner: synchroniser, debounce FSM and one-cycle press pulse on ena.
// Optional auto-repeat pulses while held are enabled by defining DEBOUNCE_AUTO_REPEAT_EN.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic clk,
  input  logic syn_reset,
  input  logic btn_in,
  output logic btn_level,
  output logic ena,
  output logic busy
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("debounce_pulse: illegal parameter value");
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ena_reg, ena_next;
  logic          s;
  logic          press_edge;
  logic          rep_fire;

  btn_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .syn_reset (syn_reset),
    .d         (btn_in),
    .q         (s)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    press_edge = 1'b0;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (s) begin
          state_next = PRESS_WAIT;
          count_next = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count_reg == CNT_MAX) begin
          state_next = PRESSED;
          count_next = '0;
          press_edge = 1'b1;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = RELEASE_WAIT;
          count_next = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
          count_next = '0;
        end else if (count_reg == CNT_MAX) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam int             RPW       = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                   REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RPW-1:0] REP_FIRST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] REP_NEXT  = RPW'(REPEAT_PERIOD - 1);

  logic [RPW-1:0] rep_cnt_reg, rep_cnt_next;
  logic           rep_first_reg, rep_first_next;

  // Counts cycles spent in PRESSED only, so RELEASE_WAIT freezes it.
  always_comb begin
    rep_cnt_next   = rep_cnt_reg;
    rep_first_next = rep_first_reg;
    rep_fire       = 1'b0;
    if (state_reg == IDLE) begin
      rep_cnt_next   = '0;
      rep_first_next = 1'b1;
    end else if (state_reg == PRESSED) begin
      if (rep_cnt_reg == (rep_first_reg ? REP_FIRST : REP_NEXT)) begin
        rep_fire       = 1'b1;
        rep_cnt_next   = '0;
        rep_first_next = 1'b0;
      end else begin
        rep_cnt_next = rep_cnt_reg + RPW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else begin
      rep_cnt_reg   <= rep_cnt_next;
      rep_first_reg <= rep_first_next;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign ena_next = press_edge | rep_fire;

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      ena_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ena_reg   <= ena_next;
    end
  end

  assign btn_level = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);
  assign busy      = (state_reg == PRESS_WAIT) || (state_reg == RELEASE_WAIT);
  assign ena       = ena_reg;

endmodule
